// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer for one single-port memory instance.
// Every op is prep+exec; reads are checked two edges after exec.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [2:0]            E_LAST = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  drain_q, drain_d;

  logic                  op_rd;
  logic                  op_val;
  logic                  single;
  logic                  down;
  logic                  next_down;
  logic                  last_op;
  logic                  last_addr;
  logic                  active;
  logic                  launch;
  logic                  miss;

  logic                  s1_v_q, s2_v_q;
  logic [DATA_WIDTH-1:0] s1_exp_q, s2_exp_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
  logic [2:0]            s1_elem_q, s2_elem_q;

  logic                  fail_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] faddr_q;
  logic [2:0]            felem_q;
  logic [DATA_WIDTH-1:0] fdata_q;

  // op table: E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 r0,w1 | E4 r1,w0 | E5 r0
  always_comb begin
    op_rd  = 1'b0;
    op_val = 1'b0;
    single = 1'b0;
    unique case (elem_q)
      3'd0: begin
        single = 1'b1;
      end
      3'd1, 3'd3: begin
        op_rd  = ~op_q;
        op_val = op_q;
      end
      3'd2, 3'd4: begin
        op_rd  = ~op_q;
        op_val = ~op_q;
      end
      3'd5: begin
        single = 1'b1;
        op_rd  = 1'b1;
      end
      default: begin
        single = 1'b1;
      end
    endcase
  end

  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign next_down = (elem_q == 3'd2) || (elem_q == 3'd3);
  assign last_op   = single | op_q;
  assign last_addr = down ? (addr_q == '0) : (addr_q == A_LAST);
  assign active    = (state_q == S_PREP) || (state_q == S_EXEC);
  assign launch    = start &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    op_d    = op_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PREP;
          elem_d  = 3'd0;
          op_d    = 1'b0;
          addr_d  = '0;
        end
      end
      S_PREP: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_PREP;
        if (!last_op) begin
          op_d = 1'b1;
        end else if (!last_addr) begin
          op_d   = 1'b0;
          addr_d = down ? addr_q - A_ONE : addr_q + A_ONE;
        end else if (elem_q == E_LAST) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          elem_d = elem_q + 3'd1;
          op_d   = 1'b0;
          addr_d = next_down ? A_LAST : '0;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  // stage 1 is loaded on the edge that ends a read exec cycle
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      s1_v_q    <= 1'b0;
      s1_exp_q  <= '0;
      s1_addr_q <= '0;
      s1_elem_q <= 3'd0;
      s2_v_q    <= 1'b0;
      s2_exp_q  <= '0;
      s2_addr_q <= '0;
      s2_elem_q <= 3'd0;
    end else begin
      s1_v_q    <= (state_q == S_EXEC) && op_rd;
      s1_exp_q  <= {DATA_WIDTH{op_val}};
      s1_addr_q <= addr_q;
      s1_elem_q <= elem_q;
      s2_v_q    <= s1_v_q;
      s2_exp_q  <= s1_exp_q;
      s2_addr_q <= s1_addr_q;
      s2_elem_q <= s1_elem_q;
    end
  end

  assign miss = s2_v_q && (mem_rdata != s2_exp_q);

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
      felem_q <= 3'd0;
      fdata_q <= '0;
    end else if (miss) begin
      fail_q <= 1'b1;
      if (!(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (!fail_q) begin
        faddr_q <= s2_addr_q;
        felem_q <= s2_elem_q;
        fdata_q <= mem_rdata;
      end
    end
  end

  assign mem_write_read = (state_q == S_EXEC) && !op_rd;
  assign mem_address    = addr_q;
  assign mem_wdata      = active ? {DATA_WIDTH{op_val}} : '0;
  assign busy           = active || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign fail           = fail_q;
  assign fail_count     = cnt_q;
  assign fail_addr      = faddr_q;
  assign fail_element   = felem_q;
  assign fail_data      = fdata_q;

endmodule
